// File: rtl/sw_ctrl_if.sv
// ---------------------------------------------------------------
// sw_ctrl_if : button inputs and control outputs of sw_ctrl
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface sw_ctrl_if;
  logic       btn_ss;
  logic       btn_lc;
  logic       run;
  logic       clr;
  logic       lap_hold;
  logic [1:0] state;

  modport master (
    output btn_ss, btn_lc,
    input  run, clr, lap_hold, state
  );

  modport slave (
    input  btn_ss, btn_lc,
    output run, clr, lap_hold, state
  );
endinterface

`default_nettype wire

// File: rtl/sw_ctrl.sv
// ---------------------------------------------------------------
// sw_ctrl : stopwatch control - button sync/debounce and run/lap FSM
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module sw_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic      clk,
  input  logic      rst,
  sw_ctrl_if.slave  bus
);

  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  // Index 0 = start/stop, index 1 = lap/clear
  logic [1:0]         w_raw;
  logic [1:0]         r_meta;
  logic [1:0]         r_sync;
  logic [1:0]         r_deb;
  logic [1:0]         r_press;
  logic [c_CNT_W-1:0] r_cnt [2];

  state_t     r_fsm;
  state_t     w_next;
  logic       w_clr_req;
  logic       r_clr_req;
  logic       r_run;
  logic       r_clr;
  logic       r_lap_hold;
  logic [1:0] r_state;

  assign w_raw = {bus.btn_lc, bus.btn_ss};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta  <= 2'b11;
      r_sync  <= 2'b11;
      r_deb   <= 2'b11;
      r_press <= 2'b00;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
      for (int i = 0; i < 2; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_CNT_LAST) begin
          // Level accepted; strobe only on the high-to-low (press) change
          r_deb[i]   <= r_sync[i];
          r_cnt[i]   <= '0;
          r_press[i] <= ~r_sync[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Start/stop has priority; a simultaneous lap/clear is dropped
  always_comb begin
    w_next    = r_fsm;
    w_clr_req = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (r_press[0])      w_next = RUN;
        else if (r_press[1]) w_clr_req = 1'b1;
      end
      RUN: begin
        if (r_press[0])      w_next = PAUSE;
        else if (r_press[1]) w_next = LAP;
      end
      LAP: begin
        if (r_press[0])      w_next = PAUSE;
        else if (r_press[1]) w_next = RUN;
      end
      PAUSE: begin
        if (r_press[0]) begin
          w_next = RUN;
        end else if (r_press[1]) begin
          w_next    = IDLE;
          w_clr_req = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs are a registered decode of the state register, one edge behind it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm      <= IDLE;
      r_clr_req  <= 1'b0;
      r_run      <= 1'b0;
      r_clr      <= 1'b0;
      r_lap_hold <= 1'b0;
      r_state    <= IDLE;
    end else begin
      r_fsm      <= w_next;
      r_clr_req  <= w_clr_req;
      r_run      <= (r_fsm == RUN) || (r_fsm == LAP);
      r_clr      <= r_clr_req;
      r_lap_hold <= (r_fsm == LAP);
      r_state    <= r_fsm;
    end
  end

  assign bus.run      = r_run;
  assign bus.clr      = r_clr;
  assign bus.lap_hold = r_lap_hold;
  assign bus.state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_sw_ctrl.sv
// ---------------------------------------------------------------
// tb_sw_ctrl : self-checking bench for sw_ctrl (DEBOUNCE_CYCLES=4)
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_sw_ctrl;

  localparam int D = 4;

  typedef struct {
    logic [1:0] st;
    logic       run;
    logic       lh;
  } exp_t;

  logic clk;
  logic rst;
  sw_ctrl_if bus();

  sw_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int clr_cycles = 0;
  int clr_rises = 0;
  int st_changes = 0;
  logic       clr_prev = 1'b0;
  logic [1:0] st_prev = 2'b00;

  always @(posedge clk) begin
    #1;
    if (bus.clr === 1'b1) begin
      clr_cycles++;
      if (clr_prev !== 1'b1) clr_rises++;
    end
    if (bus.state !== st_prev) st_changes++;
    clr_prev = bus.clr;
    st_prev  = bus.state;
  end

  task automatic press(input logic ss, input logic lc);
    @(negedge clk);
    if (ss) bus.btn_ss = 1'b0;
    if (lc) bus.btn_lc = 1'b0;
    repeat (10) @(negedge clk);
    bus.btn_ss = 1'b1;
    bus.btn_lc = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.btn_ss = 1'b1;
    bus.btn_lc = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.state, bus.run, bus.lap_hold, bus.clr} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b required 00000", {bus.state, bus.run, bus.lap_hold, bus.clr});
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.state, bus.run, bus.lap_hold, bus.clr} !== 5'b0) begin
        errors++;
        $display("FAIL idle_quiet[%0d]: got %b required 00000", i, {bus.state, bus.run, bus.lap_hold, bus.clr});
      end
    end
  endtask

  task automatic test_latency();
    exp_t e;
    int sc0;
    sc0 = st_changes;
    q.push_back('{st: 2'b01, run: 1'b1, lh: 1'b0});
    @(negedge clk);
    bus.btn_ss = 1'b0;
    for (int i = 0; i < D + 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.state !== 2'b00 || bus.run !== 1'b0) begin
        errors++;
        $display("FAIL latency_early[%0d]: got state=%b run=%b required state=00 run=0", i, bus.state, bus.run);
      end
    end
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (bus.state !== e.st || bus.run !== e.run || bus.lap_hold !== e.lh) begin
      errors++;
      $display("FAIL latency_edge: got state=%b run=%b lh=%b required state=%b run=%b lh=%b",
               bus.state, bus.run, bus.lap_hold, e.st, e.run, e.lh);
    end
    repeat (2) @(negedge clk);
    bus.btn_ss = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (st_changes - sc0 !== 1 || bus.state !== 2'b01) begin
      errors++;
      $display("FAIL single_transition: got changes=%0d state=%b required changes=1 state=01",
               st_changes - sc0, bus.state);
    end
  endtask

  task automatic test_bounce();
    int sc0;
    sc0 = st_changes;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i % 2 == 0) bus.btn_ss = ~bus.btn_ss;
    end
    bus.btn_ss = 1'b1;
    repeat (D + 6) @(negedge clk);
    checks++;
    if (st_changes != sc0 || bus.state !== 2'b01) begin
      errors++;
      $display("FAIL bounce: got changes=%0d state=%b required changes=0 state=01",
               st_changes - sc0, bus.state);
    end
  endtask

  task automatic test_lap();
    exp_t e;
    q.push_back('{st: 2'b11, run: 1'b1, lh: 1'b1});
    press(1'b0, 1'b1);
    e = q.pop_front();
    checks++;
    if (bus.state !== e.st || bus.run !== e.run || bus.lap_hold !== e.lh) begin
      errors++;
      $display("FAIL lap_enter: got state=%b run=%b lh=%b required state=%b run=%b lh=%b",
               bus.state, bus.run, bus.lap_hold, e.st, e.run, e.lh);
    end
    q.push_back('{st: 2'b01, run: 1'b1, lh: 1'b0});
    press(1'b0, 1'b1);
    e = q.pop_front();
    checks++;
    if (bus.state !== e.st || bus.run !== e.run || bus.lap_hold !== e.lh) begin
      errors++;
      $display("FAIL lap_leave: got state=%b run=%b lh=%b required state=%b run=%b lh=%b",
               bus.state, bus.run, bus.lap_hold, e.st, e.run, e.lh);
    end
  endtask

  task automatic test_pause_clear();
    exp_t e;
    int c0, r0;
    c0 = clr_cycles;
    q.push_back('{st: 2'b10, run: 1'b0, lh: 1'b0});
    press(1'b1, 1'b0);
    e = q.pop_front();
    checks++;
    if (bus.state !== e.st || bus.run !== e.run || bus.lap_hold !== e.lh || clr_cycles != c0) begin
      errors++;
      $display("FAIL pause: got state=%b run=%b lh=%b clr_cycles=%0d required state=%b run=%b lh=%b clr_cycles=0",
               bus.state, bus.run, bus.lap_hold, clr_cycles - c0, e.st, e.run, e.lh);
    end
    for (int k = 0; k < 2; k++) begin
      c0 = clr_cycles;
      r0 = clr_rises;
      q.push_back('{st: 2'b00, run: 1'b0, lh: 1'b0});
      press(1'b0, 1'b1);
      e = q.pop_front();
      checks++;
      if (bus.state !== e.st || bus.run !== e.run || bus.lap_hold !== e.lh) begin
        errors++;
        $display("FAIL clear_state[%0d]: got state=%b run=%b lh=%b required state=%b run=%b lh=%b",
                 k, bus.state, bus.run, bus.lap_hold, e.st, e.run, e.lh);
      end
      checks++;
      if (clr_cycles - c0 != 1 || clr_rises - r0 != 1) begin
        errors++;
        $display("FAIL clear_pulse[%0d]: got high_cycles=%0d pulses=%0d required 1 and 1",
                 k, clr_cycles - c0, clr_rises - r0);
      end
    end
  endtask

  task automatic test_both_and_reset();
    exp_t e;
    int c0;
    c0 = clr_cycles;
    q.push_back('{st: 2'b01, run: 1'b1, lh: 1'b0});
    press(1'b1, 1'b1);
    e = q.pop_front();
    checks++;
    if (bus.state !== e.st || bus.run !== e.run || bus.lap_hold !== e.lh || clr_cycles != c0) begin
      errors++;
      $display("FAIL both_pressed: got state=%b run=%b lh=%b clr_cycles=%0d required state=%b run=%b lh=%b clr_cycles=0",
               bus.state, bus.run, bus.lap_hold, clr_cycles - c0, e.st, e.run, e.lh);
    end
    q.push_back('{st: 2'b11, run: 1'b1, lh: 1'b1});
    press(1'b0, 1'b1);
    e = q.pop_front();
    checks++;
    if (bus.state !== e.st || bus.lap_hold !== e.lh) begin
      errors++;
      $display("FAIL both_lap: got state=%b lh=%b required state=%b lh=%b", bus.state, bus.lap_hold, e.st, e.lh);
    end
    // Begin a debounce, then reset mid-count while in LAP
    @(negedge clk);
    bus.btn_ss = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({bus.state, bus.run, bus.lap_hold, bus.clr} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: got %b required 00000", {bus.state, bus.run, bus.lap_hold, bus.clr});
    end
    bus.btn_ss = 1'b1;
    c0 = clr_cycles;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (bus.state !== 2'b00 || bus.run !== 1'b0 || clr_cycles != c0) begin
      errors++;
      $display("FAIL reset_abandon: got state=%b run=%b clr_cycles=%0d required state=00 run=0 clr_cycles=0",
               bus.state, bus.run, clr_cycles - c0);
    end
  endtask

  task automatic test_held_through_reset();
    exp_t e;
    rst = 1'b0;
    bus.btn_ss = 1'b0;
    repeat (3) @(negedge clk);
    q.push_back('{st: 2'b01, run: 1'b1, lh: 1'b0});
    rst = 1'b1;
    for (int i = 0; i < D + 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.run !== 1'b0) begin
        errors++;
        $display("FAIL held_early[%0d]: got run=%b required 0", i, bus.run);
      end
    end
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (bus.state !== e.st || bus.run !== e.run) begin
      errors++;
      $display("FAIL held_press: got state=%b run=%b required state=%b run=%b", bus.state, bus.run, e.st, e.run);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (bus.state !== 2'b01) begin
      errors++;
      $display("FAIL held_no_repeat: got state=%b required 01", bus.state);
    end
    bus.btn_ss = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    bus.btn_ss = 1'b1;
    bus.btn_lc = 1'b1;
    test_reset();
    test_latency();
    test_bounce();
    test_lap();
    test_pause_clear();
    test_both_and_reset();
    test_held_through_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sw_ctrl.md
SW_CTRL -- requirements
Module: sw_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), giving the number of consecutive stable synchronized cycles required to accept a button level change; legal range 2..2^24.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port btn_ss, input, 1 bit: raw start/stop button, asynchronous, low = pressed.
REQ-005 The block SHALL have port btn_lc, input, 1 bit: raw lap/clear button, asynchronous, low = pressed.
REQ-006 The block SHALL have port run, output, 1 bit: count enable for the downstream 10 ms tick / seconds / minutes chain; high = count.
REQ-007 The block SHALL have port clr, output, 1 bit: single-cycle pulse zeroing the downstream sec/min counters.
REQ-008 The block SHALL have port lap_hold, output, 1 bit: high = downstream display freezes its last value while counting continues.
REQ-009 The block SHALL have port state, output, 2 bits: current FSM state code for debug.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer; synchronized level lags pin by exactly 2 clk cycles.
REQ-011 Per button, a counter SHALL reset to 0 in any cycle where the synchronized level equals the debounced level, and SHALL increment otherwise. The counter width is ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-012 The debounced level SHALL take the synchronized value on the edge where the counter would reach DEBOUNCE_CYCLES. The counter returns to 0 on that same edge, so debounced lags pin by exactly DEBOUNCE_CYCLES+2 cycles.
REQ-013 Any bounce shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced level unchanged.
REQ-014 A press strobe (ss_p / lc_p) SHALL be high for exactly one cycle: the cycle in which the debounced level has just changed 1->0. Release (0->1) SHALL produce no strobe.
REQ-015 The FSM SHALL have states IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11, updated on the edge after the strobe cycle.
REQ-016 IDLE transitions:
- ss_p -> RUN
- lc_p -> stays IDLE and asserts clr.
REQ-017 RUN transitions:
- ss_p -> PAUSE
- lc_p -> LAP.
REQ-018 LAP transitions:
- ss_p -> PAUSE, which releases the display freeze
- lc_p -> RUN, which releases the freeze.
REQ-019 PAUSE transitions:
- ss_p -> RUN
- lc_p -> IDLE and asserts clr.
REQ-020 If ss_p and lc_p are high in the same cycle, ss_p SHALL be acted on and lc_p discarded; no clr is issued.
REQ-021 Outputs SHALL be registered and decoded from the state register:
- run = 1 in RUN and LAP
- lap_hold = 1 in LAP only
- state = state register.
REQ-022 clr SHALL be registered, high for exactly the one cycle following each clr-issuing transition, and low otherwise.
REQ-023 End-to-end latency SHALL be exactly DEBOUNCE_CYCLES+4 cycles, measured from the first clk edge sampling a held-low pin to run/lap_hold/clr/state reflecting the new state.
REQ-024 A button held low indefinitely SHALL produce exactly one strobe; no auto-repeat.

Reset
REQ-025 While rst=0, the block SHALL hold the following values, applied asynchronously:
- synchronizer flops and debounced levels = 1
- counters = 0, strobes = 0
- state = IDLE
- run = 0, clr = 0, lap_hold = 0.
REQ-026 A button held low through reset deassertion SHALL register one press, DEBOUNCE_CYCLES+2 cycles after release of rst.
REQ-027 Reset asserted mid-debounce or mid-LAP SHALL abandon the count and state with no clr pulse.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 The bench SHALL cover: rst low, then high; no presses for 20 cycles -> run=0, clr=0, lap_hold=0, state=00 throughout.
REQ-029 The bench SHALL cover: btn_ss low for 10 cycles from IDLE -> state=01 and run=1 exactly 8 cycles after the first low sample; exactly one transition.
REQ-030 The bench SHALL cover: btn_ss toggling every 2 cycles for 30 cycles -> no state change.
REQ-031 The bench SHALL cover: RUN, then lc press -> state=11, run=1, lap_hold=1; second lc press -> state=01, lap_hold=0.
REQ-032 The bench SHALL cover: RUN -> ss press -> PAUSE (run=0), then lc press -> state=00 with clr high for exactly 1 cycle; an lc press in IDLE gives one further clr pulse.
REQ-033 The bench SHALL cover: both buttons pressed on the same cycle from IDLE -> state=01 with no clr; rst pulsed low during LAP -> all outputs 0 immediately.
